// File: rtl/bft_leaf_port_if.sv
// Client stream and switch-facing flit signals of a BFT leaf port.
// The slave modport is the endpoint's view; master is the client/switch side.
interface bft_leaf_port_if #(
  parameter int num_leaves = 8,
  parameter int payload_sz = 32
);
  localparam int addr_w = $clog2(num_leaves);
  localparam int p_sz   = 1 + addr_w + payload_sz;

  logic                  din_valid;
  logic                  din_ready;
  logic [addr_w-1:0]     din_addr;
  logic [payload_sz-1:0] din_data;
  logic [p_sz-1:0]       bus_o;
  logic [p_sz-1:0]       bus_i;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [payload_sz-1:0] dout_data;
  logic                  rx_overflow;
  logic                  tx_self_err;
  logic [15:0]           drop_cnt;

  modport slave (
    input  din_valid, din_addr, din_data, bus_i, dout_ready,
    output din_ready, bus_o, dout_valid, dout_data, rx_overflow, tx_self_err, drop_cnt
  );

  modport master (
    output din_valid, din_addr, din_data, bus_i, dout_ready,
    input  din_ready, bus_o, dout_valid, dout_data, rx_overflow, tx_self_err, drop_cnt
  );
endinterface

// File: rtl/bft_leaf_port.sv
// Leaf endpoint of a BFT network: packetizes a client stream onto bus_o and
// buffers flits from bus_i into a show-ahead stream, counting every rx loss.
module bft_leaf_port #(
  parameter int num_leaves = 8,
  parameter int payload_sz = 32,
  parameter int this_addr  = 0,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int tx_depth   = 4,
  parameter int rx_depth   = 8
) (
  input logic             clk,
  input logic             reset,
  bft_leaf_port_if.slave  port
);
  localparam int addr_w = $clog2(num_leaves);
  localparam int tx_aw  = $clog2(tx_depth);
  localparam int rx_aw  = $clog2(rx_depth);
  localparam logic [addr_w-1:0] self_addr = addr_w'(this_addr);

  typedef struct packed {
    logic [addr_w-1:0]     addr;
    logic [payload_sz-1:0] data;
  } tx_entry_t;

  // ---------------- TX path ----------------
  tx_entry_t        tx_mem [tx_depth];
  logic [tx_aw:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic             din_ready_q, din_ready_d;
  logic [p_sz-1:0]  bus_o_q, bus_o_d;
  logic             tx_self_err_q, tx_self_err_d;
  logic             tx_empty, tx_push, tx_pop, tx_accept, self_hit;

  // ---------------- RX path ----------------
  logic [payload_sz-1:0] rx_mem [rx_depth];
  logic [p_sz-1:0]  rx_q, rx_d;
  logic [rx_aw:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             rx_overflow_q, rx_overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             rx_valid, rx_hit, rx_empty, rx_full, rx_push, rx_pop, rx_drop, rx_ovf_evt;
  logic [addr_w-1:0] rx_addr;

  always_comb begin
    // NOTE: every always_comb output gets a value up front so no path can infer a latch.
    self_hit  = port.din_addr == self_addr;
    tx_accept = port.din_valid && din_ready_q;
    tx_push   = tx_accept && !self_hit;
    tx_empty  = tx_wr_q == tx_rd_q;
    tx_pop    = !tx_empty;
    tx_wr_d   = tx_wr_q + {{tx_aw{1'b0}}, tx_push};
    tx_rd_d   = tx_rd_q + {{tx_aw{1'b0}}, tx_pop};
    // Ready is registered from next-state pointers so it equals "not full" without a comb path.
    din_ready_d = !((tx_wr_d[tx_aw] != tx_rd_d[tx_aw]) &&
                    (tx_wr_d[tx_aw-1:0] == tx_rd_d[tx_aw-1:0]));
    bus_o_d       = tx_empty ? '0 : {1'b1, tx_mem[tx_rd_q[tx_aw-1:0]]};
    tx_self_err_d = tx_self_err_q | (tx_accept && self_hit);

    rx_d       = port.bus_i;
    rx_valid   = rx_q[p_sz-1];
    rx_addr    = rx_q[p_sz-2 -: addr_w];
    rx_hit     = rx_valid && (rx_addr == self_addr);
    rx_empty   = rx_wr_q == rx_rd_q;
    rx_full    = (rx_wr_q[rx_aw] != rx_rd_q[rx_aw]) &&
                 (rx_wr_q[rx_aw-1:0] == rx_rd_q[rx_aw-1:0]);
    rx_pop     = !rx_empty && port.dout_ready;
    // A same-cycle pop frees the slot the incoming flit needs.
    rx_push    = rx_hit && (!rx_full || rx_pop);
    rx_ovf_evt = rx_hit && rx_full && !rx_pop;
    rx_drop    = rx_ovf_evt || (rx_valid && !rx_hit);
    rx_wr_d    = rx_wr_q + {{rx_aw{1'b0}}, rx_push};
    rx_rd_d    = rx_rd_q + {{rx_aw{1'b0}}, rx_pop};
    rx_overflow_d = rx_overflow_q | rx_ovf_evt;
    drop_cnt_d    = (rx_drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      din_ready_q   <= 1'b0;
      bus_o_q       <= '0;
      tx_self_err_q <= 1'b0;
      rx_q          <= '0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      rx_overflow_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      din_ready_q   <= din_ready_d;
      bus_o_q       <= bus_o_d;
      tx_self_err_q <= tx_self_err_d;
      rx_q          <= rx_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      rx_overflow_q <= rx_overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[tx_aw-1:0]] <= '{addr: port.din_addr, data: port.din_data};
    if (rx_push) rx_mem[rx_wr_q[rx_aw-1:0]] <= rx_q[payload_sz-1:0];
  end

  assign port.din_ready   = din_ready_q;
  assign port.bus_o       = bus_o_q;
  assign port.tx_self_err = tx_self_err_q;
  assign port.dout_valid  = !rx_empty;
  // Masked when empty so stale storage never leaks out after reset.
  assign port.dout_data   = rx_empty ? '0 : rx_mem[rx_rd_q[rx_aw-1:0]];
  assign port.rx_overflow = rx_overflow_q;
  assign port.drop_cnt    = drop_cnt_q;
endmodule
